instruction_queue_register: RTL and testbench

- Parametrised successor to the single-entry instruction register.
- Adds a DEPTH-entry prefetch queue in front of the opcode/operand split, so memory can deliver instructions ahead of the controller.
- Memory side uses a valid/ready push handshake; the controller pops with load_ir.
- The IR outputs, opcode and data_out, hold the most recently popped instruction until the next pop, flush or reset.

---
 rtl/instruction_queue_register.sv | 114 +++++++++++
 tb/tb_instruction_queue_register.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_queue_register.sv
// Instruction register fed by a DEPTH-entry prefetch queue; memory pushes with valid/ready, controller pops with load_ir.
// Optional IQ_BYPASS_EN: an empty-queue push coinciding with load_ir goes straight into the IR.
module instruction_queue_register #(
  parameter int INSTR_W  = 8,
  parameter int OPCODE_W = 4,
  parameter int DEPTH    = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [INSTR_W-1:0]            instr_in,
  input  logic                          instr_valid,
  output logic                          instr_ready,
  input  logic                          load_ir,
  output logic [OPCODE_W-1:0]           opcode,
  output logic [INSTR_W-OPCODE_W-1:0]   data_out,
  output logic                          ir_valid,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          empty,
  output logic                          full,
  output logic                          underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ir_valid_q, ir_valid_d;
  logic               underflow_q, underflow_d;
  logic               empty_i, full_i, push_ok, pop_ok, mem_we;

  assign empty_i = (count_q == '0);
  assign full_i  = (count_q == CNT_W'(DEPTH));
  // Ready looks only at occupancy, so a pop never frees a slot for a push in the same cycle.
  assign push_ok = instr_valid && !full_i;
  assign pop_ok  = load_ir && !empty_i;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    ir_d        = ir_q;
    ir_valid_d  = ir_valid_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;
    if (flush) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      ir_d        = '0;
      ir_valid_d  = 1'b0;
      underflow_d = 1'b0;
    end
`ifdef IQ_BYPASS_EN
    else if (empty_i && instr_valid && load_ir) begin
      ir_d       = instr_in;
      ir_valid_d = 1'b1;
    end
`endif
    else begin
      if (push_ok) begin
        mem_we = 1'b1;
        wptr_d = wptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        ir_d       = mem_q[rptr_q];
        ir_valid_d = 1'b1;
        rptr_d     = rptr_q + PTR_W'(1);
      end else if (load_ir) begin
        ir_d        = '0;
        ir_valid_d  = 1'b0;
        underflow_d = 1'b1;
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      ir_q        <= ir_d;
      ir_valid_q  <= ir_valid_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage carries no reset; pointers and count define what is live.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[wptr_q] <= instr_in;
  end

  assign opcode      = ir_q[INSTR_W-1 -: OPCODE_W];
  assign data_out    = ir_q[INSTR_W-OPCODE_W-1:0];
  assign ir_valid    = ir_valid_q;
  assign count       = count_q;
  assign empty       = empty_i;
  assign full        = full_i;
  assign instr_ready = !full_i;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_instruction_queue_register.sv
// Self-checking bench: queue-based reference model compared every cycle, plus literal spot checks.
module tb_instruction_queue_register;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] instr_in = 8'h00;
  logic       instr_valid = 1'b0;
  logic       load_ir = 1'b0;
  logic       instr_ready, ir_valid, empty, full, underflow;
  logic [3:0] opcode, data_out;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;
  bit run_chk = 1'b0;

  logic [7:0] mq[$];
  logic [7:0] m_ir = 8'h00;
  bit         m_irv = 1'b0;
  bit         m_uf = 1'b0;

`ifdef IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  instruction_queue_register #(.INSTR_W(8), .OPCODE_W(4), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush), .instr_in(instr_in),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .load_ir(load_ir),
    .opcode(opcode), .data_out(data_out), .ir_valid(ir_valid), .count(count),
    .empty(empty), .full(full), .underflow(underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_ir = 8'h00;
    m_irv = 1'b0;
    m_uf = 1'b0;
  endtask

  // Next state from the rules: flush wins, then bypass, else pop from the old head and append the push.
  task automatic model_step(input bit v, input logic [7:0] d, input bit ld, input bit fl);
    bit acc;
    if (fl) begin
      model_clear();
      return;
    end
    if (BYP && mq.size() == 0 && v && ld) begin
      m_ir = d;
      m_irv = 1'b1;
      return;
    end
    acc = v && (mq.size() < DEPTH);
    if (ld) begin
      if (mq.size() > 0) begin
        m_ir = mq.pop_front();
        m_irv = 1'b1;
      end else begin
        m_ir = 8'h00;
        m_irv = 1'b0;
        m_uf = 1'b1;
      end
    end
    if (acc) mq.push_back(d);
  endtask

  always @(negedge clock) begin
    if (run_chk) begin
      chk("opcode", opcode, m_ir[7:4]);
      chk("data_out", data_out, m_ir[3:0]);
      chk("ir_valid", ir_valid, m_irv);
      chk("count", count, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == DEPTH);
      chk("instr_ready", instr_ready, mq.size() != DEPTH);
      chk("underflow", underflow, m_uf);
    end
  end

  task automatic cycle(input bit v, input logic [7:0] d, input bit ld, input bit fl);
    @(negedge clock);
    #1;
    instr_valid = v;
    instr_in    = d;
    load_ir     = ld;
    flush       = fl;
    @(posedge clock);
    model_step(v, d, ld, fl);
    #1;
    instr_valid = 1'b0;
    load_ir     = 1'b0;
    flush       = 1'b0;
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    run_chk = 1'b1;

    // Reset state
    cycle(0, 8'h00, 0, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_data", data_out, 0);
    chk("rst_irv", ir_valid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ready", instr_ready, 1);
    chk("rst_count", count, 0);

    // Two pushes then two pops
    cycle(1, 8'hA3, 0, 0);
    cycle(1, 8'h5C, 0, 0);
    cycle(0, 8'h00, 1, 0);
    chk("pop1_opcode", opcode, 4'hA);
    chk("pop1_data", data_out, 4'h3);
    chk("pop1_irv", ir_valid, 1);
    cycle(0, 8'h00, 1, 0);
    chk("pop2_opcode", opcode, 4'h5);
    chk("pop2_data", data_out, 4'hC);
    chk("pop2_empty", empty, 1);

    // Overfill and drain, twice, crossing the pointer wrap
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) begin
        cycle(1, 8'(8'h10 * (i + 1) + r), 0, 0);
        if (i == 3) begin
          chk("fill_full", full, 1);
          chk("fill_ready", instr_ready, 0);
          chk("fill_count", count, 4);
        end
      end
      for (int i = 0; i < 4; i++) begin
        cycle(0, 8'h00, 1, 0);
        chk("drain_order", {opcode, data_out}, 8'h10 * (i + 1) + r);
      end
    end

    // Pop of full queue with push the same cycle: push refused
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h20 + i), 0, 0);
    cycle(1, 8'hEE, 1, 0);
    chk("fullpp_count", count, 3);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0);
    chk("fullpp_last", {opcode, data_out}, 8'h23);

    // Underflow after IR holds 0x7E
    cycle(1, 8'h7E, 0, 0);
    cycle(0, 8'h00, 1, 0);
    chk("ir_7e", {opcode, data_out}, 8'h7E);
    cycle(0, 8'h00, 1, 0);
    chk("uf_ir", {opcode, data_out}, 0);
    chk("uf_irv", ir_valid, 0);
    chk("uf_flag", underflow, 1);
    repeat (3) cycle(1, 8'h44, 0, 0);
    cycle(0, 8'h00, 1, 0);
    chk("uf_sticky", underflow, 1);
    cycle(0, 8'h00, 0, 1);
    chk("uf_flush", underflow, 0);

    // Flush with push and pop at count 2
    cycle(1, 8'h11, 0, 0);
    cycle(1, 8'h22, 0, 0);
    cycle(1, 8'h33, 1, 1);
    chk("fl_count", count, 0);
    chk("fl_irv", ir_valid, 0);
    chk("fl_uf", underflow, 0);
    chk("fl_ir", {opcode, data_out}, 0);
    cycle(0, 8'h00, 1, 0);
    chk("fl_pop_uf", underflow, 1);
    cycle(0, 8'h00, 0, 1);

    // Push 0x91 with load_ir on an empty queue
    cycle(1, 8'h91, 1, 0);
    if (BYP) begin
      chk("byp_ir", {opcode, data_out}, 8'h91);
      chk("byp_irv", ir_valid, 1);
      chk("byp_count", count, 0);
    end else begin
      chk("nobyp_ir", {opcode, data_out}, 0);
      chk("nobyp_uf", underflow, 1);
      chk("nobyp_count", count, 1);
    end

    // Async reset mid-stream
    cycle(1, 8'hB6, 0, 0);
    cycle(0, 8'h00, 1, 0);
    @(negedge clock);
    #3 reset = 1'b1;
    model_clear();
    #1;
    chk("arst_ir", {opcode, data_out}, 0);
    chk("arst_irv", ir_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_uf", underflow, 0);
    #1 reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 3);
    end

    @(negedge clock);
    #1 run_chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
